// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: word width, FSM
// state encodings and the default reset fetch address.
package fetch_ctrl_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] FETCH_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH_ST_IDLE = 2'b00,
        FETCH_ST_REQ  = 2'b01,
        FETCH_ST_HOLD = 2'b10,
        FETCH_ST_DROP = 2'b11
    } fetch_state_e;

    // Instruction addresses are word aligned; low two bits of a target are dropped.
    function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between fetch_ctrl, instruction memory, the NPC logic and ID.
// master = fetch_ctrl side, slave = environment side.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic                  imem_req;
    logic [WORD_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [WORD_WIDTH-1:0] imem_rdata;
    logic                  if_valid;
    logic [WORD_WIDTH-1:0] if_inst;
    logic [WORD_WIDTH-1:0] if_pc;
    logic                  if_ready;
    logic                  redirect_valid;
    logic [WORD_WIDTH-1:0] redirect_pc;
    logic                  flush;

    modport master (
        output imem_req, imem_addr, if_valid, if_inst, if_pc, flush,
        input  imem_ack, imem_rdata, if_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_inst, if_pc, flush,
        output imem_ack, imem_rdata, if_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_ctrl_perf_cnt.sv
// Wrapping performance counters for fetch_ctrl (handoffs, redirects, stalls).
// Only instantiated when FETCH_CTRL_PERF_EN is defined.
module fetch_perf_cnt
    import fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_handoff,
    input  logic                  i_redirect,
    input  logic                  i_stall,
    output logic [WORD_WIDTH-1:0] o_perf_fetch,
    output logic [WORD_WIDTH-1:0] o_perf_redirect,
    output logic [WORD_WIDTH-1:0] o_perf_stall
);

    logic [WORD_WIDTH-1:0] r_fetch;
    logic [WORD_WIDTH-1:0] r_redirect;
    logic [WORD_WIDTH-1:0] r_stall;

    // Event counters; each simply wraps at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch    <= 32'd0;
            r_redirect <= 32'd0;
            r_stall    <= 32'd0;
        end else begin
            r_fetch    <= r_fetch    + {31'd0, i_handoff};
            r_redirect <= r_redirect + {31'd0, i_redirect};
            r_stall    <= r_stall    + {31'd0, i_stall};
        end
    end

    assign o_perf_fetch    = r_fetch;
    assign o_perf_redirect = r_redirect;
    assign o_perf_stall    = r_stall;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives imem req/ack, buffers one
// instruction for ID and squashes wrong-path fetches. Optional: FETCH_CTRL_PERF_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_ctrl_if.master          bus
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [WORD_WIDTH-1:0] perf_fetch,
    output logic [WORD_WIDTH-1:0] perf_redirect,
    output logic [WORD_WIDTH-1:0] perf_stall
`endif
);

    fetch_state_e          r_state, w_state_nxt;
    logic [WORD_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [WORD_WIDTH-1:0] r_tgt, w_tgt_nxt;
    logic [WORD_WIDTH-1:0] r_inst, w_inst_nxt;
    logic [WORD_WIDTH-1:0] r_if_pc, w_if_pc_nxt;
    logic [WORD_WIDTH-1:0] w_redir_pc;

    assign w_redir_pc = align_word(bus.redirect_pc);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_ST_IDLE;
            r_pc    <= RESET_PC;
            r_tgt   <= 32'd0;
            r_inst  <= 32'd0;
            r_if_pc <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_inst  <= w_inst_nxt;
            r_if_pc <= w_if_pc_nxt;
        end
    end

    // Next-state logic; DROP keeps the request up until the wrong-path ack arrives.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_inst_nxt  = r_inst;
        w_if_pc_nxt = r_if_pc;
        case (r_state)
            FETCH_ST_IDLE: begin
                w_state_nxt = FETCH_ST_REQ;
            end
            FETCH_ST_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid) begin
                        w_pc_nxt = w_redir_pc;
                    end else begin
                        w_inst_nxt  = bus.imem_rdata;
                        w_if_pc_nxt = r_pc;
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = FETCH_ST_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    w_tgt_nxt   = w_redir_pc;
                    w_state_nxt = FETCH_ST_DROP;
                end else begin
                    w_state_nxt = FETCH_ST_REQ;
                end
            end
            FETCH_ST_DROP: begin
                if (bus.redirect_valid) begin
                    w_tgt_nxt = w_redir_pc;
                end else begin
                    w_tgt_nxt = r_tgt;
                end
                if (bus.imem_ack) begin
                    w_pc_nxt    = bus.redirect_valid ? w_redir_pc : r_tgt;
                    w_state_nxt = FETCH_ST_REQ;
                end else begin
                    w_state_nxt = FETCH_ST_DROP;
                end
            end
            FETCH_ST_HOLD: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = FETCH_ST_REQ;
                end else if (bus.if_ready) begin
                    w_state_nxt = FETCH_ST_REQ;
                end else begin
                    w_state_nxt = FETCH_ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = FETCH_ST_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = (r_state == FETCH_ST_REQ) || (r_state == FETCH_ST_DROP);
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = (r_state == FETCH_ST_HOLD);
    assign bus.if_inst   = r_inst;
    assign bus.if_pc     = r_if_pc;
    assign bus.flush     = bus.redirect_valid;

`ifdef FETCH_CTRL_PERF_EN
    logic w_handoff;
    logic w_stall;

    assign w_handoff = (r_state == FETCH_ST_HOLD) && bus.if_ready && !bus.redirect_valid;
    assign w_stall   = (r_state == FETCH_ST_HOLD) && !bus.if_ready;

    fetch_perf_cnt u_perf (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_handoff       (w_handoff),
        .i_redirect      (bus.redirect_valid),
        .i_stall         (w_stall),
        .o_perf_fetch    (perf_fetch),
        .o_perf_redirect (perf_redirect),
        .o_perf_stall    (perf_stall)
    );
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the 5-stage MIPS pipeline. Owns the architectural PC register and issues requests to instruction memory over a req/ack handshake that tolerates variable latency. Hands fetched instructions to ID over a valid/ready handshake. Accepts redirect targets (taken branch, j/jal, jr) computed by the NPC logic, and discards wrong-path fetches, including one still in flight.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
clk            in   1   clock; all state updates on the rising edge
rst_n          in   1   asynchronous, active-low reset
imem_req       out  1   fetch request; held high until imem_ack
imem_addr      out  32  fetch address, word aligned; stable while imem_req=1
imem_ack       in   1   memory returns imem_rdata this cycle; may arrive in the same cycle as imem_req
imem_rdata     in   32  instruction word
if_valid       out  1   if_inst and if_pc are valid for ID
if_inst        out  32  fetched instruction
if_pc          out  32  address of if_inst
if_ready       in   1   ID accepts; deasserted by the hazard unit on stall
redirect_valid in   1   taken control transfer; one-cycle pulse from NPC selection
redirect_pc    in   32  target address; bits [1:0] ignored and forced to 00
flush          out  1   combinational; high in any cycle where redirect_valid=1

Behaviour:
- Reset, asynchronous on rst_n=0:
  - pc_q=RESET_PC, state=IDLE.
  - imem_req=0, if_valid=0, if_inst=0, if_pc=0.
  - Reset mid-transaction abandons it. Any later ack that is not preceded by a new req is ignored.
- States: IDLE, REQ, HOLD, DROP.
- IDLE:
  - Entered only from reset. Moves to REQ on the next cycle, so the first imem_req appears in the 2nd cycle after rst_n rises.
- REQ:
  - imem_req=1, imem_addr=pc_q.
  - ack and no redirect: capture if_inst=imem_rdata and if_pc=pc_q; pc_q<=pc_q+4 (wraps modulo 2^32); go to HOLD.
  - ack and redirect in the same cycle: discard the data; pc_q<=redirect_pc; stay in REQ, issuing a new request next cycle.
  - redirect without ack: latch tgt_q=redirect_pc; go to DROP.
- DROP:
  - imem_req stays 1 and the address stays unchanged; a request is never retracted.
  - A further redirect overwrites tgt_q; the last one wins.
  - On ack: discard the data; pc_q<=tgt_q, or redirect_pc if a redirect arrives in that same cycle; go to REQ.
- HOLD:
  - if_valid=1; if_inst and if_pc are held stable while if_ready=0.
  - if_ready=1 and no redirect: handoff occurs; if_valid<=0; go to REQ.
  - redirect in any cycle of HOLD: the buffered instruction is wrong-path. flush=1; if_valid<=0; pc_q<=redirect_pc; go to REQ.
  - If if_ready=1 in the same cycle as a redirect, the handoff is void; ID must gate its capture with !flush.
- Throughput and latency:
  - Zero-wait memory with ID always ready gives one instruction every 2 cycles.
  - Redirect-to-first-request latency: 1 cycle from REQ or HOLD; from DROP, 1 cycle after the pending ack.
- imem_req and if_valid are never high together; the design holds a single-entry buffer.

Optional Feature:
FETCH_CTRL_PERF_EN
- Defined: adds three 32-bit wrapping counters, all cleared by rst_n:
  - perf_fetch (out 32): completed handoffs.
  - perf_redirect (out 32): cycles with redirect_valid=1.
  - perf_stall (out 32): cycles in HOLD with if_ready=0.
- Undefined: these ports and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header holds:
  - WORD_WIDTH
  - FETCH_ST_IDLE/REQ/HOLD/DROP, 2-bit encodings
  - default RESET_PC value
- One sub-module, fetch_perf_cnt: the three counters, instantiated only under FETCH_CTRL_PERF_EN.

Test Plan:
- Reset then zero-wait memory, if_ready=1 → imem_addr sequence 0x3000, 0x3004, 0x3008, with if_valid pulses every 2nd cycle carrying the matching if_pc.
- ack delayed 3 cycles at 0x3000 → imem_req high for 4 cycles with a stable address; if_inst=imem_rdata; next request is 0x3004.
- HOLD with if_ready=0 for 5 cycles → if_valid, if_inst and if_pc held; no new imem_req. With the perf feature on, perf_stall=5.
- Redirect to 0x4010 while in REQ without ack, then ack 2 cycles later → data discarded, no if_valid; next imem_addr=0x4010.
- Redirect 0x5000, then 0x6000, both in DROP → next request is 0x6000. Separately, redirect together with if_ready in HOLD → flush=1 and the handoff is not counted.
- pc_q=0xFFFF_FFFC with ack → next imem_addr=0x0000_0000. Separately, assert rst_n=0 while in DROP → outputs return to reset values immediately.
